ram_dp_param: RTL and testbench

- Parametrised simple-dual-port synchronous RAM. Successor to the fixed 8x8 RAM; default parameters give the same 8-word x 8-bit geometry.
- One write port and one read port with registered, 1-cycle-latency read data and a read-valid strobe.
- Selectable read-during-write mode.
- Built-in post-reset clear sequencer that writes INIT_VAL to every word, with a busy flag.
- Sits beside the register/memory subsystem as the general storage primitive for FIFOs and scratchpads.

---
 rtl/ram_dp_param.sv | 170 +++++++++++++++++
 tb/tb_ram_dp_param.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_param.sv
// ram_dp_param: parametrised simple-dual-port synchronous RAM.
// It has one write port and one read port. Read data is registered and
// arrives one cycle after the read is issued, together with a rd_valid strobe.
// The RDW_MODE parameter selects what a read returns when it hits the word
// being written on the same edge.
// After reset, a clear sequencer writes INIT_VAL to every word. busy is high
// while the sequencer runs, and all accesses are ignored during that time.
// Optional macro RAM_PARITY_EN adds an even-parity bit to each stored word
// and a parity_err output that is checked on every accepted read.
module ram_dp_param #(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 8,
    parameter int               ADDR_W   = $clog2(DEPTH),
    parameter int               RDW_MODE = 0,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_enb,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              rd_enb,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  data_out,
    output logic              rd_valid,
    output logic              busy
`ifdef RAM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

`ifdef RAM_PARITY_EN
    localparam int MEM_W = WIDTH + 1;
`else
    localparam int MEM_W = WIDTH;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // When parity is enabled, the parity bit sits above the data bits.
    function automatic logic [MEM_W-1:0] f_encode(input logic [WIDTH-1:0] d);
`ifdef RAM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_next;

    logic [MEM_W-1:0]  r_mem [DEPTH];
    logic [WIDTH-1:0]  r_dout;
    logic              r_valid;

    logic              w_busy;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [MEM_W-1:0]  w_mem_wdata;
    logic [MEM_W-1:0]  w_rd_word;

    assign w_busy  = (r_state == ST_CLEAR);
    assign w_wr_ok = wr_enb && !w_busy;
    assign w_rd_ok = rd_enb && !w_busy;

    // State and clear counter. Reset restarts the clear sequence from word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state: step through every word once, then stay ready. The counter
    // stops on the last word instead of wrapping.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_CLEAR: begin
                if (r_cnt == LAST_ADDR) begin
                    w_state_next = ST_READY;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_READY: begin
                w_state_next = ST_READY;
            end
            default: begin
                w_state_next = ST_CLEAR;
                w_cnt_next   = '0;
            end
        endcase
    end

    // One shared write port. The clear sequencer owns it while busy is high;
    // otherwise the user write port owns it.
    always_comb begin
        w_mem_we    = w_busy || w_wr_ok;
        w_mem_waddr = w_busy ? r_cnt : wr_addr;
        w_mem_wdata = w_busy ? f_encode(INIT_VAL) : f_encode(data_in);
    end

    // Memory array. It has no reset, and it is not written while rst is held.
    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Read-word source. In write-through mode, a read that hits the word
    // being written returns the incoming word. In read-first mode, the array
    // read naturally sees the pre-write contents.
    generate
        if (RDW_MODE == 1) begin : g_rdw_new
            logic w_bypass;
            assign w_bypass  = w_wr_ok && (wr_addr == rd_addr);
            assign w_rd_word = w_bypass ? f_encode(data_in) : r_mem[rd_addr];
        end else begin : g_rdw_old
            assign w_rd_word = r_mem[rd_addr];
        end
    endgenerate

    // Registered read data and strobe. data_out holds when no read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_dout <= w_rd_word[WIDTH-1:0];
            end
        end
    end

`ifdef RAM_PARITY_EN
    logic r_perr;

    // Parity check. The flag is registered alongside the read data and is
    // cleared on every cycle that has no accepted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perr <= 1'b0;
        end else if (w_rd_ok) begin
            r_perr <= (w_rd_word[WIDTH] != ^w_rd_word[WIDTH-1:0]);
        end else begin
            r_perr <= 1'b0;
        end
    end

    assign parity_err = r_perr;
`endif

    assign data_out = r_dout;
    assign rd_valid = r_valid;
    assign busy     = w_busy;

endmodule

// File: tb/tb_ram_dp_param.sv
// Testbench for ram_dp_param. Two instances share one stimulus stream:
//   dut_a: default 8x8, read-first, INIT_VAL 0
//   dut_b: 32x16, write-through, INIT_VAL 0xBEEF
// A reference memory per instance predicts each read result. The expected
// result is queued when the read is issued, and a monitor pops and compares
// it when the instance raises rd_valid.
module tb_ram_dp_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_enb = 1'b0;
    logic        rd_enb = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [4:0]  rd_addr = '0;
    logic [15:0] din = '0;

    logic [7:0]  dout_a;
    logic        valid_a;
    logic        busy_a;
    logic [15:0] dout_b;
    logic        valid_b;
    logic        busy_b;
`ifdef RAM_PARITY_EN
    logic        perr_a;
    logic        perr_b;
`endif

    always #5 clk = ~clk;

    ram_dp_param #(.WIDTH(8), .DEPTH(8), .RDW_MODE(0), .INIT_VAL(8'h00)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .wr_enb   (wr_enb),
        .wr_addr  (wr_addr[2:0]),
        .data_in  (din[7:0]),
        .rd_enb   (rd_enb),
        .rd_addr  (rd_addr[2:0]),
        .data_out (dout_a),
        .rd_valid (valid_a),
        .busy     (busy_a)
`ifdef RAM_PARITY_EN
        ,
        .parity_err (perr_a)
`endif
    );

    ram_dp_param #(.WIDTH(16), .DEPTH(32), .RDW_MODE(1), .INIT_VAL(16'hBEEF)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .wr_enb   (wr_enb),
        .wr_addr  (wr_addr),
        .data_in  (din),
        .rd_enb   (rd_enb),
        .rd_addr  (rd_addr),
        .data_out (dout_b),
        .rd_valid (valid_b),
        .busy     (busy_b)
`ifdef RAM_PARITY_EN
        ,
        .parity_err (perr_b)
`endif
    );

    typedef struct {
        int unsigned cyc;
        logic [15:0] d;
        logic        perr;
    } exp_t;

    // Reference model: per instance, a word array, the number of clear edges
    // still to run, the value data_out should be holding, and the read queue.
    int          depth_m [2] = '{8, 32};
    logic [15:0] mask_m  [2] = '{16'h00FF, 16'hFFFF};
    logic [15:0] init_m  [2] = '{16'h0000, 16'hBEEF};
    int          mode_m  [2] = '{0, 1};
    logic [15:0] mm      [2][32];
    int          rem     [2] = '{0, 0};
    logic [15:0] hold    [2] = '{16'h0, 16'h0};
    bit          exp_busy[2] = '{1'b0, 1'b0};
    exp_t        qa[$];
    exp_t        qb[$];
    bit          perr_next_a = 1'b0;

    int unsigned edge_cnt = 0;
    bit          chk_on = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic cmp(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d edge %0d: got %h expected %h", name, k, edge_cnt, act, exp);
        end
    endtask

    // Advance the reference model of instance k by one clock edge.
    task automatic model_edge(input int k, input bit r, input bit we, input int wa,
                              input logic [15:0] wd, input bit re, input int ra);
        int   a_w;
        int   a_r;
        exp_t e;
        a_w = wa % depth_m[k];
        a_r = ra % depth_m[k];
        if (r) begin
            rem[k]  = depth_m[k];
            hold[k] = 16'h0;
        end else if (rem[k] > 0) begin
            mm[k][depth_m[k] - rem[k]] = init_m[k];
            rem[k]--;
        end else begin
            if (re) begin
                e.cyc = edge_cnt + 1;
                e.d   = mm[k][a_r];
                if (we && a_w == a_r && mode_m[k] == 1) e.d = wd & mask_m[k];
                e.perr = (k == 0) ? perr_next_a : 1'b0;
                if (k == 0) perr_next_a = 1'b0;
                hold[k] = e.d;
                if (k == 0) qa.push_back(e); else qb.push_back(e);
            end
            if (we) mm[k][a_w] = wd & mask_m[k];
        end
        exp_busy[k] = (rem[k] != 0);
    endtask

    // Drive one cycle of stimulus at the falling edge and update the model
    // for the rising edge that follows.
    task automatic cyc(input bit r, input bit we, input int wa, input int wd,
                       input bit re, input int ra);
        @(negedge clk);
        rst     = r;
        wr_enb  = we;
        wr_addr = 5'(wa);
        din     = 16'(wd);
        rd_enb  = re;
        rd_addr = 5'(ra);
        if (r) chk_on = 1'b1;
        model_edge(0, r, we, wa, 16'(wd), re, ra);
        model_edge(1, r, we, wa, 16'(wd), re, ra);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic check(input int k, input logic [15:0] dout, input logic valid,
                         input logic bsy, input logic perr);
        exp_t e;
        bit   ev;
        ev = 1'b0;
        e.cyc = 0; e.d = '0; e.perr = 1'b0;
        if (k == 0) begin
            if (qa.size() > 0 && qa[0].cyc == edge_cnt) begin e = qa.pop_front(); ev = 1'b1; end
        end else begin
            if (qb.size() > 0 && qb[0].cyc == edge_cnt) begin e = qb.pop_front(); ev = 1'b1; end
        end
        cmp("busy", k, 16'(bsy), 16'(exp_busy[k]));
        cmp("rd_valid", k, 16'(valid), 16'(ev));
        if (ev) cmp("read_data", k, dout, e.d);
        else    cmp("data_hold", k, dout, hold[k]);
`ifdef RAM_PARITY_EN
        cmp("parity_err", k, 16'(perr), 16'(ev ? e.perr : 1'b0));
`else
        if (perr !== 1'b0) cmp("parity_err", k, 16'(perr), 16'h0);
`endif
    endtask

    // Monitor: sample one time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_on) begin
`ifdef RAM_PARITY_EN
                check(0, {8'h0, dout_a}, valid_a, busy_a, perr_a);
                check(1, dout_b, valid_b, busy_b, perr_b);
`else
                check(0, {8'h0, dout_a}, valid_a, busy_a, 1'b0);
                check(1, dout_b, valid_b, busy_b, 1'b0);
`endif
            end
        end
    end

    initial begin
        int wa;
        int ra;
        // Power-up reset, then let both clears finish.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(33);
        // Preload every word, then reset for two edges and release.
        for (int i = 0; i < 32; i++) cyc(0, 1, i, 16'h5A00 + i, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        // Accesses while busy must be ignored.
        cyc(0, 1, 4, 16'h00AA, 1, 4);
        for (int i = 1; i < 8; i++) cyc(0, 1, 4, 16'h00AA, 1, i);
        idle(25);
        for (int i = 0; i < 32; i++) cyc(0, 0, 0, 0, 1, i);
        // Three writes, then three back-to-back reads.
        cyc(0, 1, 2, 25, 0, 0);
        cyc(0, 1, 6, 99, 0, 0);
        cyc(0, 1, 1, 42, 0, 0);
        cyc(0, 0, 0, 0, 1, 2);
        cyc(0, 0, 0, 0, 1, 6);
        cyc(0, 0, 0, 0, 1, 1);
        idle(2);
        // Read during a write to the same word.
        cyc(0, 1, 3, 16'h11, 0, 0);
        cyc(0, 1, 3, 16'h22, 1, 3);
        cyc(0, 0, 0, 0, 1, 3);
        idle(2);
        // Reset in the middle of a clear.
        cyc(1, 0, 0, 0, 0, 0);
        idle(10);
        cyc(1, 0, 0, 0, 0, 0);
        idle(32);
        for (int i = 0; i < 32; i++) cyc(0, 0, 0, 0, 1, i);
`ifdef RAM_PARITY_EN
        // Parity: a clean read, then a read after flipping a stored data bit.
        cyc(0, 1, 5, 16'h07, 0, 0);
        cyc(0, 0, 0, 0, 1, 5);
        @(negedge clk);
        dut_a.r_mem[5] = dut_a.r_mem[5] ^ 9'h001;
        mm[0][5] = mm[0][5] ^ 16'h0001;
        perr_next_a = 1'b1;
        cyc(0, 0, 0, 0, 1, 5);
        idle(2);
`endif
        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            wa = int'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 31));
            cyc(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1, wa,
                int'($urandom_range(0, 65535)), $urandom_range(0, 2) != 0, ra);
        end
        idle(4);
        n_cmp++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_reads: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
